// File: rtl/spi_peripheral_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_peripheral_pkg
// Purpose  : Shared FSM state type, register map and frame constants.
// Revision : 1.0 - initial release
// ============================================================================
package spi_peripheral_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int ADDR_EN_OUT_LO = 'h00;
    localparam int ADDR_EN_OUT_HI = 'h01;
    localparam int ADDR_EN_PWM_LO = 'h02;
    localparam int ADDR_EN_PWM_HI = 'h03;
    localparam int ADDR_PWM_DUTY  = 'h04;

    localparam int FRAME_BITS = 16;

    // One past a full frame, so over-length frames stay distinguishable.
    localparam logic [4:0] CNT_SAT = 5'd17;

endpackage : spi_peripheral_pkg
`default_nettype wire

// File: rtl/spi_peripheral_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Multi-flop synchronizer with one extra stage for rise/fall detect.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/spi_peripheral.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_peripheral
// Purpose  : SPI mode-0 write-only register slave, 16-bit frames, clk domain.
// Revision : 1.0 - initial release
// ============================================================================
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    // Storage always covers the five mapped outputs even if NUM_REGS is smaller.
    localparam int REG_SLOTS = (NUM_REGS > 5) ? NUM_REGS : 5;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst(rst), .d(copi),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .d(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};

    state_t          state_q, state_d;
    logic [15:0]     shift_q, shift_d;
    logic [4:0]      count_q, count_d;
    logic            pend_q,  pend_d;
    logic [7:0]      regs_q [REG_SLOTS];
    logic [7:0]      regs_d [REG_SLOTS];
    logic [6:0]      addr;
    logic            commit_ok;

    assign addr = shift_q[14:8];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        pend_d  = pend_q;
        for (int i = 0; i < REG_SLOTS; i++) begin
            regs_d[i] = regs_q[i];
        end
        commit_ok = (count_q == 5'(FRAME_BITS)) && shift_q[FRAME_BITS-1]
                    && (int'(addr) < NUM_REGS);

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall || pend_q) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    count_d = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_lvl};
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            ST_COMMIT: begin
                for (int i = 0; i < REG_SLOTS; i++) begin
                    if (commit_ok && (int'(addr) == i)) begin
                        regs_d[i] = shift_q[7:0];
                    end
                end
                // A new frame may start while committing; remember it for IDLE.
                if (ncs_fall) begin
                    pend_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            for (int i = 0; i < REG_SLOTS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            for (int i = 0; i < REG_SLOTS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];

endmodule : spi_peripheral
`default_nettype wire

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_peripheral
// Purpose  : Scoreboard bench for spi_peripheral with directed SPI frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    spi_peripheral #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] vec;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [7:0]  model [5];
    logic [39:0] prev;
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    wire [39:0] obs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                       en_reg_out_15_8, en_reg_out_7_0};

    function automatic logic [39:0] model_vec();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every output change must match the next queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev = obs;
        end else if (obs !== prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_change actual=%h required=%h", obs, prev);
            end else begin
                e = exp_q.pop_front();
                n_tests++;
                if (obs !== e.vec) begin
                    n_fail++;
                    $display("FAIL commit_value actual=%h required=%h", obs, e.vec);
                end
                n_tests++;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL commit_latency actual_cycle=%0d required_cycle=%0d", cyc, e.cyc);
                end
            end
            prev = obs;
        end
    end

    task automatic cs_low();
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        copi = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [16:0] bits, input int n);
        logic [15:0] w;
        cs_low();
        for (int i = n - 1; i >= 0; i--) shift_bit(bits[i]);
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        w = bits[15:0];
        if (n == 16 && w[15] && w[14:8] < 7'd5) begin
            for (int a = 0; a < 5; a++) begin
                if (int'(w[14:8]) == a) model[a] = w[7:0];
            end
            exp_q.push_back('{vec: model_vec(), cyc: cyc + 4});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout actual_pending=%0d required_pending=0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all(input string name);
        n_tests++;
        if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, obs, model_vec());
        end
    endtask

    task automatic check_reg(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_each(input string tag, input logic [39:0] req);
        check_reg({tag, "_out_lo"}, en_reg_out_7_0,  req[7:0]);
        check_reg({tag, "_out_hi"}, en_reg_out_15_8, req[15:8]);
        check_reg({tag, "_pwm_lo"}, en_reg_pwm_7_0,  req[23:16]);
        check_reg({tag, "_pwm_hi"}, en_reg_pwm_15_8, req[31:24]);
        check_reg({tag, "_duty"},   pwm_duty_cycle,  req[39:32]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] abort_word;
        rst  = 1'b1;
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_each("reset", 40'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_frame({1'b0, 16'h80F0}, 16);
        drain();
        check_all("write_80F0");

        send_frame({1'b0, 16'h8480}, 16);
        drain();
        check_reg("duty_80", pwm_duty_cycle, 8'h80);
        send_frame({1'b0, 16'h84FF}, 16);
        drain();
        check_reg("duty_FF", pwm_duty_cycle, 8'hFF);

        send_frame({1'b0, 16'h01AA}, 16);
        send_frame({1'b0, 16'h8555}, 16);
        drain();
        check_all("discard_read_oor");

        send_frame({1'b0, 16'h8122}, 16);
        drain();
        send_frame({2'b00, 15'h40D5}, 15);
        send_frame({16'h81AB, 1'b1}, 17);
        drain();
        check_reg("short_long_out_hi", en_reg_out_15_8, 8'h22);

        // Reset pulse after bit 10; the rest of the frame must be ignored.
        abort_word = 16'h83FF;
        cs_low();
        for (int i = 15; i >= 6; i--) shift_bit(abort_word[i]);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        for (int i = 5; i >= 0; i--) shift_bit(abort_word[i]);
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (4) @(negedge clk);
        drain();
        check_each("abort", 40'h0);

        send_frame({1'b0, 16'h83FF}, 16);
        drain();
        check_reg("after_abort_pwm_hi", en_reg_pwm_15_8, 8'hFF);

        send_frame({1'b0, 16'h8011}, 16);
        send_frame({1'b0, 16'h8122}, 16);
        send_frame({1'b0, 16'h8233}, 16);
        send_frame({1'b0, 16'h8344}, 16);
        send_frame({1'b0, 16'h8455}, 16);
        drain();
        check_each("b2b", 40'h55_44_33_22_11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_peripheral
`default_nettype wire

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on sclk, copi and ncs (minimum 2).
REQ-002 Parameter NUM_REGS, default 5, sets the count of writable registers (addresses 0x00..NUM_REGS-1).
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 copi  input  1  SPI controller-out/peripheral-in data, asynchronous to clk.
REQ-007 ncs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-008 en_reg_out_7_0  output  8  register 0x00, output enables for bits 7:0.
REQ-009 en_reg_out_15_8  output  8  register 0x01, output enables for bits 15:8.
REQ-010 en_reg_pwm_7_0  output  8  register 0x02, PWM enables for bits 7:0.
REQ-011 en_reg_pwm_15_8  output  8  register 0x03, PWM enables for bits 15:8.
REQ-012 pwm_duty_cycle  output  8  register 0x04, PWM duty cycle (0x00 = 0%, 0xFF = 100%).

Function
REQ-013 sclk, copi and ncs shall each pass through a SYNC_STAGES-deep flip-flop synchronizer before any use.
REQ-014 One further register stage per synchronized signal shall provide the edge detection for sclk rise, ncs fall and ncs rise.
REQ-015 The SPI protocol is mode 0: copi is sampled on the synchronized sclk rising edge, MSB first.
REQ-016 A frame is exactly 16 bits: bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data.
REQ-017 FSM states: IDLE, SHIFT, COMMIT.
REQ-018 IDLE -> SHIFT on ncs fall; the action clears the 16-bit shift register and the 5-bit bit counter.
REQ-019 In SHIFT, each sclk rise shifts copi into the LSB and increments the bit counter; the counter saturates at 17.
REQ-020 SHIFT -> COMMIT on ncs rise.
REQ-021 COMMIT -> IDLE unconditionally after one cycle.
REQ-022 In COMMIT, the addressed register is written only if all three hold: count == 16, bit15 == 1, and address < NUM_REGS.
REQ-023 Frames that fail any REQ-022 condition are discarded silently with no register change (short, long, read, out-of-range).
REQ-024 Latency: a register output changes on the (SYNC_STAGES+2)th clk rising edge after the raw ncs rise, i.e. the 4th edge at default.
REQ-025 sclk high and low phases shall each be at least SYNC_STAGES+1 clk periods; slower sclk is unbounded.
REQ-026 The ncs setup and hold around the first and last sclk edge shall each be at least SYNC_STAGES+1 clk periods.
REQ-027 An sclk rise in IDLE (ncs high) shall be ignored.
REQ-028 An ncs fall while in SHIFT cannot occur; an ncs fall in COMMIT shall be honoured on the next IDLE cycle.
REQ-029 Back-to-back frames shall each commit independently, including writes to the same address, where the last write wins.
REQ-030 Outputs are driven directly from flops, with no combinational path from the inputs.

Reset
REQ-031 Asserting rst shall immediately clear all synchronizers, the shift register and the counter, force the FSM to IDLE, and set all five registers to 0x00.
REQ-032 Reset asserted mid-frame shall abort the frame with no commit.
REQ-033 After rst deasserts, a frame whose ncs fall came before the deassertion is discarded; the next full frame is accepted.

Structure
REQ-034 A shared package shall hold:
- the FSM state enum
- the register address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_PWM_DUTY=0x04
- the frame width constant FRAME_BITS=16
REQ-035 One sub-module, sync_edge_detect (synchronizer plus rise/fall detect), shall be instantiated three times; everything else is flat.

Verification
REQ-036 Write frame 0x80F0 -> en_reg_out_7_0 = 0xF0 on the 4th clk after ncs rise; all other registers remain 0x00.
REQ-037 Write frame 0x8480 -> pwm_duty_cycle = 0x80; a following frame 0x84FF -> pwm_duty_cycle = 0xFF.
REQ-038 Read frame 0x01AA (bit15 = 0) and write frame 0x8555 (address 0x05) -> no register changes.
REQ-039 A 15-bit frame and a 17-bit frame, each carrying 0x81xx -> en_reg_out_15_8 remains at its prior value.
REQ-040 rst pulsed after bit 10 of frame 0x83FF, then a full frame 0x83FF -> en_reg_pwm_15_8 = 0x00 after the pulse, then 0xFF after the second frame.
REQ-041 Five back-to-back frames with minimal ncs gap, writing 0x11..0x55 to 0x00..0x04 -> every register holds its value, with no drops.
